// File: rtl/seg7_to_code_decoder.sv
// Receive side of the 2-bit code / 7-segment link: debounce, decode, deliver once over Valid/Ready.
// Optional transfer counter output Char_Count is enabled by defining SEG7_DEC_COUNT_EN.
module seg7_to_code_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [0:6] Seg,
  output logic [1:0] Code,
  output logic       Valid,
  input  logic       Ready,
  output logic       Err,
  output logic       Overflow
`ifdef SEG7_DEC_COUNT_EN
  ,
  output logic [7:0] Char_Count
`endif
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [0:6]    BLANK   = 7'b1111111;

  typedef enum logic {SETTLE = 1'b0, HOLD = 1'b1} state_t;

  // Returns {known, code} for an active-low pattern.
  function automatic logic [2:0] decode(input logic [0:6] p);
    case (p)
      7'b0100001: decode = 3'b100;
      7'b0000110: decode = 3'b101;
      7'b1111001: decode = 3'b110;
      7'b1000000: decode = 3'b111;
      default:    decode = 3'b000;
    endcase
  endfunction

  logic [0:6]    seg_q, seg_d;
  logic [0:6]    last_pat_q, last_pat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  logic          changed, qualify, known;
  logic [0:6]    pat;
  logic [2:0]    dec;
  logic [1:0]    new_code;

  always_comb begin
    seg_d      = Seg;
    changed    = (Seg != seg_q);
    cnt_d      = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    qualify    = (state_q == SETTLE) && (cnt_q == CNT_MAX);
    pat        = ACTIVE_LOW ? seg_q : ~seg_q;
    dec        = decode(pat);
    known      = dec[2];
    new_code   = dec[1:0];

    state_d    = state_q;
    last_pat_d = last_pat_q;
    code_d     = code_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    ovf_d      = 1'b0;

    // A change always re-arms qualification, even in the qualifying cycle itself.
    if (changed) begin
      state_d = SETTLE;
    end else if (qualify) begin
      state_d = HOLD;
    end

    if (valid_q && Ready) begin
      valid_d = 1'b0;
    end

    if (qualify && (pat != last_pat_q)) begin
      last_pat_d = pat;
      if (pat != BLANK) begin
        if (!known) begin
          err_d = 1'b1;
        end else if (!valid_q || Ready) begin
          code_d  = new_code;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      seg_q      <= BLANK;
      last_pat_q <= BLANK;
      cnt_q      <= '0;
      state_q    <= SETTLE;
      code_q     <= 2'b00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      last_pat_q <= last_pat_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign Code     = code_q;
  assign Valid    = valid_q;
  assign Err      = err_q;
  assign Overflow = ovf_q;

`ifdef SEG7_DEC_COUNT_EN
  logic [7:0] char_count_q, char_count_d;

  // Saturating count of completed transfers.
  always_comb begin
    char_count_d = char_count_q;
    if (valid_q && Ready && (char_count_q != 8'hFF)) begin
      char_count_d = char_count_q + 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      char_count_q <= 8'd0;
    end else begin
      char_count_q <= char_count_d;
    end
  end

  assign Char_Count = char_count_q;
`endif

endmodule

// File: tb/tb_seg7_to_code_decoder.sv
// Self-checking bench for seg7_to_code_decoder: run-length model plus directed scenarios.
module tb_seg7_to_code_decoder;

  localparam int S = 4;
  localparam logic [6:0] P_D     = 7'b0100001;
  localparam logic [6:0] P_E     = 7'b0000110;
  localparam logic [6:0] P_1     = 7'b1111001;
  localparam logic [6:0] P_0     = 7'b1000000;
  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_BAD   = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [0:6] seg;
  logic [1:0] code;
  logic       valid, err, ovf;
`ifdef SEG7_DEC_COUNT_EN
  logic [7:0] char_count;
`endif

  seg7_to_code_decoder dut (
    .Clock    (clk),
    .Reset    (rst),
    .Seg      (seg),
    .Code     (code),
    .Valid    (valid),
    .Ready    (rdy),
    .Err      (err),
    .Overflow (ovf)
`ifdef SEG7_DEC_COUNT_EN
    ,
    .Char_Count (char_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pattern qualifies once it has been sampled S+1 times in a row;
  // its effect appears at the following edge.
  logic [6:0] tbl [4] = '{P_D, P_E, P_1, P_0};

  function automatic int lookup(input logic [6:0] p);
    lookup = -1;
    for (int i = 0; i < 4; i++) if (tbl[i] == p) lookup = i;
  endfunction

  bit         armed = 1'b0;
  bit         m_valid, m_err, m_ovf, pend, acc, emitted;
  logic [1:0] m_code;
  logic [6:0] m_last, prev, pend_pat, cur;
  int         run, m_cnt, k;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed = 1'b1;
      m_valid = 1'b0; m_code = 2'b00; m_err = 1'b0; m_ovf = 1'b0;
      m_last = P_BLANK; prev = P_BLANK; run = 1; pend = 1'b0; m_cnt = 0;
    end else if (armed) begin
      acc = m_valid && rdy;
      emitted = 1'b0;
      m_err = 1'b0;
      m_ovf = 1'b0;
      if (acc && m_cnt < 255) m_cnt++;
      if (pend && pend_pat != m_last) begin
        m_last = pend_pat;
        k = lookup(pend_pat);
        if (pend_pat != P_BLANK) begin
          if (k < 0) m_err = 1'b1;
          else if (!m_valid || rdy) begin
            m_code = 2'(k);
            m_valid = 1'b1;
            emitted = 1'b1;
          end else m_ovf = 1'b1;
        end
      end
      if (acc && !emitted) m_valid = 1'b0;
      cur = seg;
      if (cur == prev) run++; else run = 1;
      prev = cur;
      pend = (run == S + 1);
      pend_pat = cur;
    end
  end

  // Per-scenario statistics gathered from the DUT outputs.
  int         n_xfer, n_vcyc, n_err_p, n_ovf_p, first_valid, first_err, t_set;
  logic [1:0] last_code;

  always @(negedge clk) begin
    if (armed) begin
      check("valid", 32'(valid), 32'(m_valid));
      check("code",  32'(code),  32'(m_code));
      check("err",   32'(err),   32'(m_err));
      check("ovf",   32'(ovf),   32'(m_ovf));
`ifdef SEG7_DEC_COUNT_EN
      check("char_count", 32'(char_count), 32'(m_cnt));
`endif
    end
    if (armed && !rst) begin
      if (valid) begin
        n_vcyc++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (valid && rdy) begin
        n_xfer++;
        last_code = code;
      end
      if (err) begin
        n_err_p++;
        if (first_err < 0) first_err = cyc;
      end
      if (ovf) n_ovf_p++;
    end
  end

  task automatic clr();
    n_xfer = 0; n_vcyc = 0; n_err_p = 0; n_ovf_p = 0;
    first_valid = -1; first_err = -1; last_code = 2'b00;
    t_set = cyc;
  endtask

  task automatic hold(input logic [6:0] p, input int n, input logic r);
    seg = p;
    rdy = r;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    seg = P_BLANK;
    rdy = 1'b0;
    clr();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_valid", 32'(valid), 0);
    check("rst_code",  32'(code),  0);
    check("rst_err",   32'(err),   0);
    check("rst_ovf",   32'(ovf),   0);
    rst = 1'b0;

    // 1: 'd' held, Ready=1
    clr();
    hold(P_D, 10, 1'b1);
    check("t1_latency", first_valid - t_set, 6);
    check("t1_vcycles", n_vcyc, 1);
    check("t1_xfers",   n_xfer, 1);
    check("t1_code",    32'(last_code), 0);

    // 2: short 'E' then stable '1'
    clr();
    hold(P_E, 3, 1'b1);
    hold(P_1, 8, 1'b1);
    check("t2_xfers", n_xfer, 1);
    check("t2_code",  32'(last_code), 2);
    check("t2_errs",  n_err_p, 0);

    // 3: overflow with Ready=0, then drain
    hold(P_BLANK, 6, 1'b0);
    clr();
    hold(P_1, 7, 1'b0);
    check("t3_valid_held", 32'(valid), 1);
    check("t3_code_held",  32'(code), 2);
    hold(P_0, 7, 1'b0);
    check("t3_ovf_pulses", n_ovf_p, 1);
    check("t3_code_kept",  32'(code), 2);
    clr();
    hold(P_0, 3, 1'b1);
    check("t3_drain_xfers", n_xfer, 1);
    check("t3_drain_valid", 32'(valid), 0);

    // 4: unknown pattern
    clr();
    hold(P_BAD, 7, 1'b0);
    check("t4_err_pulses", n_err_p, 1);
    check("t4_err_latency", first_err - t_set, 6);
    check("t4_no_valid", n_vcyc, 0);
    check("t4_no_ovf", n_ovf_p, 0);

    // 5: glitch vs blank
    clr();
    hold(P_0, 7, 1'b1);
    hold(P_E, 2, 1'b1);
    hold(P_0, 7, 1'b1);
    check("t5_glitch_xfers", n_xfer, 1);
    check("t5_glitch_code", 32'(last_code), 3);
    hold(P_BLANK, 6, 1'b1);
    hold(P_0, 7, 1'b1);
    check("t5_blank_xfers", n_xfer, 2);
    check("t5_blank_code", 32'(last_code), 3);

    // 6: reset while a character is pending
    hold(P_E, 7, 1'b0);
    check("t6_valid_before", 32'(valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_valid_after", 32'(valid), 0);
    check("t6_code_after",  32'(code), 0);
`ifdef SEG7_DEC_COUNT_EN
    check("t6_count_reset", 32'(char_count), 0);
`endif
    rst = 1'b0;

`ifdef SEG7_DEC_COUNT_EN
    clr();
    for (int i = 0; i < 150; i++) begin
      hold(P_D, 6, 1'b1);
      hold(P_E, 6, 1'b1);
    end
    hold(P_BLANK, 3, 1'b1);
    check("t6_xfers_300", n_xfer, 300);
    check("t6_count_sat", 32'(char_count), 255);
`else
    hold(P_D, 7, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
